// File: rtl/issue_queue_nway.sv
// Circular issue queue between decode and issue: up to PUSH_W in-order pushes and POP_W head
// lanes per cycle, with all-or-nothing push, clamped pop and a sticky over-pop error flag.
module issue_queue_nway #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PUSH_W   = 4,
  parameter int unsigned POP_W    = 2,
  parameter int unsigned AF_LEVEL = DEPTH - PUSH_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [PUSH_W*DATA_W-1:0]         in_data,
  input  logic [$clog2(PUSH_W+1)-1:0]      in_count,
  input  logic [$clog2(POP_W+1)-1:0]       pop_count,
  output logic [POP_W*DATA_W-1:0]          out_data,
  output logic [POP_W-1:0]                 out_valid,
  output logic [$clog2(DEPTH+1)-1:0]       size,
  output logic [$clog2(DEPTH+1)-1:0]       size_left,
  output logic                             almost_full,
  output logic                             push_reject,
  output logic                             pop_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_size;
  logic              r_push_reject;
  logic              r_pop_err;

  logic [CNT_W-1:0]  w_size_left;
  logic [CNT_W-1:0]  w_in_cnt;
  logic [CNT_W-1:0]  w_pop_req;
  logic [CNT_W-1:0]  w_pop_eff;
  logic [CNT_W-1:0]  w_push_eff;
  logic [CNT_W-1:0]  w_size_next;
  logic              w_push_ok;
  logic              w_over_pop;

  // Push acceptance uses the occupancy before this cycle's pop, so a full queue refuses even
  // when issue frees space in the same cycle.
  always_comb begin
    w_size_left = CNT_W'(DEPTH) - r_size;
    w_in_cnt    = CNT_W'(in_count);
    w_pop_req   = CNT_W'(pop_count);
    w_push_ok   = (w_in_cnt <= w_size_left);
    w_over_pop  = (w_pop_req > r_size);
    w_pop_eff   = w_over_pop ? r_size : w_pop_req;
    w_push_eff  = w_push_ok ? w_in_cnt : '0;
    w_size_next = r_size - w_pop_eff + w_push_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_size        <= '0;
      r_push_reject <= 1'b0;
      r_pop_err     <= 1'b0;
    end else if (flush) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_size        <= '0;
      r_push_reject <= 1'b0;
    end else begin
      r_head        <= r_head + PTR_W'(w_pop_eff);
      r_tail        <= r_tail + PTR_W'(w_push_eff);
      r_size        <= w_size_next;
      r_push_reject <= ~w_push_ok;
      if (w_over_pop) begin
        r_pop_err <= 1'b1;
      end
    end
  end

  // Storage is not reset; lanes beyond the occupancy are masked on the read side.
  always_ff @(posedge clk) begin
    if (!flush && w_push_ok) begin
      for (int i = 0; i < PUSH_W; i++) begin
        if (w_in_cnt > CNT_W'(i)) begin
          r_mem[r_tail + PTR_W'(i)] <= in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int i = 0; i < POP_W; i++) begin
      if (r_size > CNT_W'(i)) begin
        out_valid[i]                  = 1'b1;
        out_data[i*DATA_W +: DATA_W]  = r_mem[r_head + PTR_W'(i)];
      end
    end
  end

  assign size        = r_size;
  assign size_left   = w_size_left;
  assign almost_full = (r_size >= CNT_W'(AF_LEVEL));
  assign push_reject = r_push_reject;
  assign pop_err     = r_pop_err;

endmodule

// File: tb/tb_issue_queue_nway.sv
// Bench for issue_queue_nway (DEPTH=8, PUSH_W=4, POP_W=2, DATA_W=8, AF_LEVEL=4): a queue-based
// reference model checked every cycle, plus literal expectations for the directed scenarios.
module tb_issue_queue_nway;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] in_data;
  logic [2:0]  in_count;
  logic [1:0]  pop_count;
  logic [15:0] out_data;
  logic [1:0]  out_valid;
  logic [3:0]  size;
  logic [3:0]  size_left;
  logic        almost_full;
  logic        push_reject;
  logic        pop_err;

  issue_queue_nway #(
    .DATA_W  (8),
    .DEPTH   (8),
    .PUSH_W  (4),
    .POP_W   (2),
    .AF_LEVEL(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_data    (in_data),
    .in_count   (in_count),
    .pop_count  (pop_count),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .size       (size),
    .size_left  (size_left),
    .almost_full(almost_full),
    .push_reject(push_reject),
    .pop_err    (pop_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  logic [7:0] q[$];
  logic       m_rej = 0;
  logic       m_err = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    int sz;
    int p;
    bit acc;
    sz  = q.size();
    acc = (int'(in_count) <= 8 - sz);
    if (flush) begin
      q.delete();
      m_rej = 0;
    end else begin
      p = (int'(pop_count) < sz) ? int'(pop_count) : sz;
      if (int'(pop_count) > sz) m_err = 1;
      repeat (p) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < int'(in_count); i++) q.push_back(in_data[i*8 +: 8]);
      end
      m_rej = !acc;
    end
  endtask

  task automatic check_model();
    logic [15:0] ed;
    logic [1:0]  ev;
    ed = '0;
    ev = '0;
    for (int i = 0; i < 2; i++) begin
      if (i < q.size()) begin
        ed[i*8 +: 8] = q[i];
        ev[i]        = 1'b1;
      end
    end
    chk("model_size", 32'(size), 32'(q.size()));
    chk("model_size_left", 32'(size_left), 32'(8 - q.size()));
    chk("model_almost_full", 32'(almost_full), 32'(q.size() >= 4));
    chk("model_out_valid", 32'(out_valid), 32'(ev));
    chk("model_out_data", 32'(out_data), 32'(ed));
    chk("model_push_reject", 32'(push_reject), 32'(m_rej));
    chk("model_pop_err", 32'(pop_err), 32'(m_err));
  endtask

  always @(negedge clk) if (check_en) check_model();

  task automatic step(input logic f, input int cnt, input logic [31:0] d, input int pc);
    @(negedge clk);
    flush     = f;
    in_count  = 3'(cnt);
    in_data   = d;
    pop_count = 2'(pc);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_size"}, 32'(size), 32'd0);
    chk({tag, "_size_left"}, 32'(size_left), 32'd8);
    chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_push_reject"}, 32'(push_reject), 32'd0);
    chk({tag, "_pop_err"}, 32'(pop_err), 32'd0);
  endtask

  initial begin
    rst = 1; flush = 0; in_data = '0; in_count = '0; pop_count = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 0;
    check_en = 1;

    // 1: basic push
    step(0, 3, 32'h00332211, 0);
    chk("s1_size", 32'(size), 32'd3);
    chk("s1_size_left", 32'(size_left), 32'd5);
    chk("s1_out_data", 32'(out_data), 32'h2211);
    chk("s1_out_valid", 32'(out_valid), 32'b11);
    chk("s1_almost_full", 32'(almost_full), 32'd0);

    // 2: refusal when not enough room, then exact fill
    step(0, 3, 32'h00665544, 0);
    chk("s2_size6", 32'(size), 32'd6);
    step(0, 3, 32'h00998877, 0);
    chk("s2_reject", 32'(push_reject), 32'd1);
    chk("s2_size_kept", 32'(size), 32'd6);
    chk("s2_data_kept", 32'(out_data), 32'h2211);
    step(0, 2, 32'h0000bbaa, 0);
    chk("s2_full_size", 32'(size), 32'd8);
    chk("s2_full_af", 32'(almost_full), 32'd1);
    chk("s2_reject_clear", 32'(push_reject), 32'd0);

    // 3: full queue refuses a push even with a same-cycle pop
    step(0, 1, 32'h000000cc, 2);
    chk("s3_reject", 32'(push_reject), 32'd1);
    chk("s3_size", 32'(size), 32'd6);
    chk("s3_out_data", 32'(out_data), 32'h4433);

    // 4: drain, move head/tail to 6, then a push that wraps past entry 7
    step(0, 0, 0, 2);
    step(0, 0, 0, 2);
    step(0, 0, 0, 2);
    chk("s4_empty", 32'(size), 32'd0);
    step(0, 4, 32'h04030201, 0);
    step(0, 2, 32'h00000605, 2);
    chk("s4_pushpop_size", 32'(size), 32'd4);
    chk("s4_pushpop_data", 32'(out_data), 32'h0403);
    step(0, 0, 0, 2);
    step(0, 0, 0, 2);
    step(0, 4, 32'ha3a2a1a0, 0);
    chk("s4_wrap_size", 32'(size), 32'd4);
    chk("s4_wrap_data0", 32'(out_data), 32'ha1a0);
    step(0, 0, 0, 2);
    chk("s4_wrap_data1", 32'(out_data), 32'ha3a2);
    step(0, 0, 0, 2);
    chk("s4_wrap_empty", 32'(out_valid), 32'd0);
    chk("s4_no_err", 32'(pop_err), 32'd0);

    // 5: over-pop clamps and sets the sticky error
    step(0, 1, 32'h0000005a, 0);
    chk("s5_size1", 32'(size), 32'd1);
    step(0, 0, 0, 2);
    chk("s5_size", 32'(size), 32'd0);
    chk("s5_valid", 32'(out_valid), 32'd0);
    chk("s5_data", 32'(out_data), 32'd0);
    chk("s5_err", 32'(pop_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      chk("s5_err_sticky", 32'(pop_err), 32'd1);
    end

    // 6: flush overrides push/pop and clears push_reject; pop_err survives
    step(0, 4, 32'hb3b2b1b0, 0);
    step(0, 1, 32'h000000b4, 0);
    chk("s6_size5", 32'(size), 32'd5);
    step(0, 4, 32'hc3c2c1c0, 0);
    chk("s6_pre_reject", 32'(push_reject), 32'd1);
    step(1, 4, 32'hc3c2c1c0, 2);
    chk("s6_flush_size", 32'(size), 32'd0);
    chk("s6_flush_left", 32'(size_left), 32'd8);
    chk("s6_flush_reject", 32'(push_reject), 32'd0);
    chk("s6_flush_err_kept", 32'(pop_err), 32'd1);

    // Asynchronous reset mid-cycle at size 3
    step(0, 3, 32'h00d3d2d1, 0);
    chk("s6_size3", 32'(size), 32'd3);
    #2;
    rst = 1;
    q.delete();
    m_rej = 0;
    m_err = 0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #2;
    rst = 0;
    step(0, 2, 32'h0000e2e1, 0);
    chk("post_rst_size", 32'(size), 32'd2);
    chk("post_rst_data", 32'(out_data), 32'he2e1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
